pc_fetch_unit: RTL

//  Instruction-fetch stage directly upstream of SCPU_ctrl. Holds the PC, fetches
//  one 32-bit word per instruction through a req/ready handshake, and presents

---
 rtl/pc_fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, req/ready fetch handshake and next-PC selection.
// Defining IFU_TIMEOUT_EN adds a fetch timeout counter, fetch_err flag and HALT state.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [31:0] PC_out,
    input  logic        inst_ready,
    input  logic [31:0] inst_in,
    output logic [31:0] inst_out,
    output logic [5:0]  OPcode,
    output logic [5:0]  Fun,
    output logic        inst_valid,
    input  logic        stall,
    input  logic [1:0]  Branch,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] PC_plus4,
    output logic        fetch_err
);

`ifdef IFU_TIMEOUT_EN
    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_HALT} state_t;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_timeout;
`else
    typedef enum logic {S_FETCH, S_ISSUE} state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] w_next_pc;
    logic [31:0] w_br_offset;
    logic        w_latch;
    logic        w_retire;

    assign PC_out      = r_pc;
    assign PC_plus4    = r_pc + 32'd4;
    assign inst_out    = r_inst;
    assign OPcode      = r_inst[31:26];
    assign Fun         = r_inst[5:0];
    assign w_br_offset = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};

    always_comb begin
        unique case (Branch)
            2'b00:   w_next_pc = PC_plus4;
            2'b01:   w_next_pc = zero ? (PC_plus4 + w_br_offset) : PC_plus4;
            2'b10:   w_next_pc = {PC_plus4[31:28], r_inst[25:0], 2'b00};
            default: w_next_pc = rs_data;
        endcase
    end

    // NOTE: every output and strobe gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        inst_req    = 1'b0;
        inst_valid  = 1'b0;
        w_latch     = 1'b0;
        w_retire    = 1'b0;
`ifdef IFU_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                inst_req = 1'b1;
                if (inst_ready) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
`ifdef IFU_TIMEOUT_EN
                // A ready arriving on the final counted cycle still wins over the timeout.
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_HALT;
                end
`endif
            end
            S_ISSUE: begin
                inst_valid = 1'b1;
                if (!stall) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch)  r_inst <= inst_in;
            if (w_retire) r_pc   <= w_next_pc;
        end
    end

`ifdef IFU_TIMEOUT_EN
    // The counter sits at zero outside FETCH, so it starts clean on every FETCH entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != S_FETCH)
                r_cnt <= '0;
            else if (!inst_ready)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign fetch_err = r_err;
`else
    assign fetch_err = 1'b0;
`endif

endmodule
